// File: rtl/rst_seq_pkg.sv
// Shared encodings for the board reset sequencer: FSM states and reset-cause codes.
package rst_seq_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned CAUSE_W = 2;

    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_RELEASE   = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_TRAP_WAIT = 2'd3;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_BTN  = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_TRAP = 2'd3;

endpackage

// File: rtl/rst_debounce.sv
// Board button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle press pulse that re-arms only after the level drops.
module rst_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_req
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             fired;
    logic [CNT_W-1:0] cnt;

    // Any low sample reloads the count and re-arms the pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            fired   <= 1'b0;
            cnt     <= RELOAD;
            btn_req <= 1'b0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            btn_req <= 1'b0;
            if (!sync2) begin
                cnt   <= RELOAD;
                fired <= 1'b0;
            end else if (!fired) begin
                if (cnt == '0) begin
                    btn_req <= 1'b1;
                    fired   <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Board reset sequencer: stretches POR/button resets, releases domain resets in
// index order, and re-runs the sequence on software request or CPU trap.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int unsigned N_DOMAINS       = 3,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned HOLD_CYCLES     = 65535,
    parameter int unsigned GAP_CYCLES      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter bit          TRAP_RESET      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_rst_btn,
    input  logic                 sw_rst_req,
    input  logic                 trap,
    output logic [N_DOMAINS-1:0] sys_rst,
    output logic                 rst_done,
    output logic                 busy,
    output logic [CAUSE_W-1:0]   rst_cause
);

    localparam int unsigned      IDX_W       = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_DOMAINS - 1);

    logic [STATE_W-1:0]   state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_dec;
    logic [IDX_W-1:0]     idx, idx_nxt, idx_inc;
    logic [N_DOMAINS-1:0] sys_rst_nxt;
    logic                 done_nxt;
    logic                 busy_nxt;
    logic [CAUSE_W-1:0]   cause_nxt;
    logic                 trap_q;
    logic                 trap_rise;
    logic                 btn_req;
    logic                 enter_hold;
    logic [CAUSE_W-1:0]   hold_cause;

    rst_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(ext_rst_btn),
        .btn_req(btn_req)
    );

    assign trap_rise = trap & ~trap_q;
    assign idx_inc   = idx + 1'b1;
    assign cnt_dec   = (cnt == '0) ? cnt : cnt - 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_HOLD;
            cnt       <= HOLD_RELOAD;
            idx       <= '0;
            trap_q    <= 1'b0;
            sys_rst   <= '1;
            rst_done  <= 1'b0;
            busy      <= 1'b1;
            rst_cause <= CAUSE_POR;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            trap_q    <= trap;
            sys_rst   <= sys_rst_nxt;
            rst_done  <= done_nxt;
            busy      <= busy_nxt;
            rst_cause <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        sys_rst_nxt = sys_rst;
        done_nxt    = rst_done;
        cause_nxt   = rst_cause;
        enter_hold  = 1'b0;
        hold_cause  = CAUSE_POR;

        case (state)
            ST_HOLD, ST_RELEASE: begin
                if (btn_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_BTN;
                end else if (sw_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt_dec;
                end else begin
                    cnt_nxt = GAP_RELOAD;
                    if (state == ST_HOLD) begin
                        idx_nxt        = '0;
                        sys_rst_nxt[0] = 1'b0;
                        if (N_DOMAINS == 1) begin
                            state_nxt = ST_RUN;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RELEASE;
                        end
                    end else begin
                        idx_nxt = idx_inc;
                        for (int unsigned i = 1; i < N_DOMAINS; i++) begin
                            if (IDX_W'(i) == idx_inc) sys_rst_nxt[i] = 1'b0;
                        end
                        if (idx_inc == LAST_IDX) begin
                            state_nxt = ST_RUN;
                            done_nxt  = 1'b1;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (btn_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_BTN;
                end else if (sw_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (TRAP_RESET && trap_rise) begin
                    state_nxt = ST_TRAP_WAIT;
                    cnt_nxt   = GAP_RELOAD;
                end
            end
            ST_TRAP_WAIT: begin
                // Expiry outranks a coincident software request (trap > software).
                if (btn_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_BTN;
                end else if (cnt == '0) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_TRAP;
                end else if (sw_rst_req) begin
                    enter_hold = 1'b1;
                    hold_cause = CAUSE_SW;
                end else begin
                    cnt_nxt = cnt_dec;
                end
            end
            default: begin
                enter_hold = 1'b1;
                hold_cause = CAUSE_POR;
            end
        endcase

        if (enter_hold) begin
            state_nxt   = ST_HOLD;
            cnt_nxt     = HOLD_RELOAD;
            idx_nxt     = '0;
            sys_rst_nxt = '1;
            done_nxt    = 1'b0;
            cause_nxt   = hold_cause;
        end

        busy_nxt = (state_nxt != ST_RUN);
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a time-based reference model predicts every
// cycle's outputs for a trap-enabled and a trap-disabled instance.
module tb_rst_seq_ctrl;

    localparam int N     = 3;
    localparam int CW    = 16;
    localparam int H     = 8;
    localparam int G     = 4;
    localparam int D     = 5;
    localparam int TDONE = H + (N - 1) * G;

    typedef struct packed {
        logic [N-1:0] sys_rst;
        logic         done;
        logic         busy;
        logic [1:0]   cause;
    } obs_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn;
    logic         sw;
    logic         trap;
    logic [N-1:0] sys_rst0, sys_rst1;
    logic         done0, done1, busy0, busy1;
    logic [1:0]   cause0, cause1;

    int checks = 0;
    int errors = 0;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    // Reference model: time since the last HOLD entry, plus a trap-wait start time.
    int         n;
    int         rl_q[$];
    bit         trap_prev;
    bit         in_twait[2];
    int         hold_start[2];
    int         tw_start[2];
    logic [1:0] m_cause[2];

    always #5 clk = ~clk;

    rst_seq_ctrl #(
        .N_DOMAINS(N), .CNT_W(CW), .HOLD_CYCLES(H), .GAP_CYCLES(G),
        .DEBOUNCE_CYCLES(D), .TRAP_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .ext_rst_btn(btn), .sw_rst_req(sw), .trap(trap),
        .sys_rst(sys_rst0), .rst_done(done0), .busy(busy0), .rst_cause(cause0)
    );

    rst_seq_ctrl #(
        .N_DOMAINS(N), .CNT_W(CW), .HOLD_CYCLES(H), .GAP_CYCLES(G),
        .DEBOUNCE_CYCLES(D), .TRAP_RESET(1'b0)
    ) dut_nt (
        .clk(clk), .rst(rst), .ext_rst_btn(btn), .sw_rst_req(sw), .trap(trap),
        .sys_rst(sys_rst1), .rst_done(done1), .busy(busy1), .rst_cause(cause1)
    );

    task automatic model_reset();
        n = 0;
        rl_q.delete();
        rl_q.push_back(0);
        trap_prev = 1'b0;
        for (int j = 0; j < 2; j++) begin
            in_twait[j]   = 1'b0;
            hold_start[j] = 0;
            tw_start[j]   = 0;
            m_cause[j]    = 2'd0;
        end
    endtask

    task automatic enter_hold(input int j, input logic [1:0] c);
        in_twait[j]   = 1'b0;
        hold_start[j] = n;
        m_cause[j]    = c;
    endtask

    // A press is accepted 3 edges after the raw level completes D consecutive high samples.
    task automatic model_edge(input bit b, input bit s, input bit t);
        int rl_now;
        bit press;
        bit rise;
        bit running;
        n++;
        rl_now = b ? rl_q[n-1] + 1 : 0;
        rl_q.push_back(rl_now);
        press = (n >= 3) && (rl_q[n-3] == D);
        rise  = t && !trap_prev;
        trap_prev = t;
        for (int j = 0; j < 2; j++) begin
            running = !in_twait[j] && ((n - 1 - hold_start[j]) >= TDONE);
            if (press) begin
                enter_hold(j, 2'd1);
            end else if (in_twait[j]) begin
                if (n - tw_start[j] >= G) enter_hold(j, 2'd3);
                else if (s)               enter_hold(j, 2'd2);
            end else if (s) begin
                enter_hold(j, 2'd2);
            end else if (running && rise && j == 0) begin
                in_twait[j] = 1'b1;
                tw_start[j] = n;
            end
        end
    endtask

    function automatic obs_t expect_out(input int j);
        obs_t o;
        int   t;
        o.cause = m_cause[j];
        if (in_twait[j]) begin
            o.sys_rst = '0;
            o.done    = 1'b1;
            o.busy    = 1'b1;
        end else begin
            t = n - hold_start[j];
            for (int i = 0; i < N; i++) o.sys_rst[i] = (t < H + i * G);
            o.done = (t >= TDONE);
            o.busy = !o.done;
        end
        return o;
    endfunction

    // One clock of stimulus; optionally pulls rst low mid-cycle after the edge.
    task automatic cycle(input bit b, input bit s, input bit t, input bit drop);
        btn  = b;
        sw   = s;
        trap = t;
        @(posedge clk);
        if (rst) model_edge(b, s, t);
        else     model_reset();
        if (drop) begin
            #2;
            rst = 1'b0;
            model_reset();
        end
        exp_q0.push_back(expect_out(0));
        exp_q1.push_back(expect_out(1));
        #1;
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q0.size() != 0) begin
            e = exp_q0.pop_front();
            a = {sys_rst0, done0, busy0, cause0};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out_trap_en t=%0t act sys_rst=%b done=%b busy=%b cause=%0d exp sys_rst=%b done=%b busy=%b cause=%0d",
                         $time, a.sys_rst, a.done, a.busy, a.cause, e.sys_rst, e.done, e.busy, e.cause);
            end
        end
        if (exp_q1.size() != 0) begin
            e = exp_q1.pop_front();
            a = {sys_rst1, done1, busy1, cause1};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL out_trap_dis t=%0t act sys_rst=%b done=%b busy=%b cause=%0d exp sys_rst=%b done=%b busy=%b cause=%0d",
                         $time, a.sys_rst, a.done, a.busy, a.cause, e.sys_rst, e.done, e.busy, e.cause);
            end
        end
    end

    initial begin
        bit rb;
        bit rt;
        bit drop;
        rst  = 1'b0;
        btn  = 1'b0;
        sw   = 1'b0;
        trap = 1'b0;
        rb   = 1'b0;
        rt   = 1'b0;
        model_reset();
        repeat (3) cycle(0, 0, 0, 0);
        rst = 1'b1;

        // Power-on sequence
        repeat (20) cycle(0, 0, 0, 0);

        // Bouncy button, then steady press
        for (int i = 0; i < 10; i++) cycle(((i / 2) % 2) == 0, 0, 0, 0);
        repeat (10) cycle(1, 0, 0, 0);
        repeat (25) cycle(0, 0, 0, 0);

        // Software reset; trap raised during HOLD and held high
        cycle(0, 1, 0, 0);
        repeat (25) cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Trap rise in RUN
        repeat (25) cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Software and trap together, then button pulse and software together
        cycle(0, 1, 1, 0);
        repeat (22) cycle(0, 0, 0, 0);
        repeat (D + 2) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        repeat (22) cycle(0, 0, 0, 0);

        // Software request in RELEASE, then async reset mid-RELEASE
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        rst = 1'b1;
        repeat (10) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (10) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        rst = 1'b1;
        repeat (20) cycle(0, 0, 0, 0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9) == 0)  rb = ~rb;
            if ($urandom_range(0, 24) == 0) rt = ~rt;
            drop = ($urandom_range(0, 699) == 0);
            cycle(rb, $urandom_range(0, 79) == 0, rt, drop);
            if (drop) begin
                cycle(rb, 0, rt, 0);
                rst = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Board-level reset sequencer that sits between the board reset and clock and the system domains (CPU/interconnect, UART, GPIO).
- Stretches power-on and button resets.
- Releases per-domain resets in a fixed staged order.
- Re-issues a full reset sequence on a software request or a CPU trap.
- Reports the cause of the last reset.

Parameters:
N_DOMAINS, 3, number of reset outputs; released in index order 0..N_DOMAINS-1
CNT_W, 16, width of the shared down-counter
HOLD_CYCLES, 65535, cycles all outputs stay asserted in HOLD (1..2^CNT_W-1)
GAP_CYCLES, 16, cycles between successive domain releases, and trap-to-reset delay (1..2^CNT_W-1)
DEBOUNCE_CYCLES, 1000, consecutive stable synchronized samples needed to accept a button press (1..2^CNT_W-1)
TRAP_RESET, 1, 1 = a trap rising edge triggers a full reset sequence; 0 = trap ignored

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous and active-low; one clock only
ext_rst_btn  input  1  raw board reset button, active-high, asynchronous, bouncy
sw_rst_req  input  1  single-cycle synchronous software reset request (GPIO/CSR)
trap  input  1  CPU trap level, synchronous to clk
sys_rst  output  N_DOMAINS  per-domain active-high resets
rst_done  output  1  high once all domains are released
busy  output  1  high in every state except RUN
rst_cause  output  2  cause of the last sequence: 0 POR, 1 button, 2 software, 3 trap

Behaviour:
- Clocking: single clock; rst asynchronous and active-low. All flops clear asynchronously on rst low.
- Reset values: sys_rst all ones, rst_done 0, busy 1, rst_cause 0, state HOLD, counter HOLD_CYCLES-1, domain index 0.
- Button path:
  - 2-flop synchronizer, then debounce counter.
  - The request pulse btn_req lasts one cycle. It fires when the synchronized level has been high for DEBOUNCE_CYCLES consecutive cycles.
  - Any low sample reloads the counter.
  - It does not re-fire until the level has gone low and been re-debounced.
- Trap path: registered trap; trap_rise = trap & ~trap_q.
- States:
  - HOLD: sys_rst all ones. Counter decrements each cycle. At 0, go to RELEASE: sys_rst[0] cleared on that edge, idx=0, counter=GAP_CYCLES-1. So sys_rst[0] falls exactly HOLD_CYCLES cycles after HOLD entry.
  - RELEASE: counter decrements. At 0, idx+1 and sys_rst[idx+1] cleared, counter reloaded. When the last domain is cleared, go to RUN and set rst_done on the same edge. With N_DOMAINS=1, HOLD goes directly to RUN.
  - RUN: rst_done=1, busy=0.
    - btn_req or sw_rst_req → HOLD.
    - trap_rise with TRAP_RESET=1 → TRAP_WAIT, counter=GAP_CYCLES-1.
  - TRAP_WAIT: outputs unchanged. Counter decrements; at 0 → HOLD. A btn_req or sw_rst_req here → HOLD immediately.
- Entering HOLD, on the same edge: sys_rst all ones, rst_done 0, counter=HOLD_CYCLES-1, rst_cause updated.
- Simultaneous requests, cause priority: button > trap > software.
- Requests during HOLD or RELEASE restart HOLD: counter reloaded, all outputs reasserted, cause updated. A trap_rise during HOLD/RELEASE is ignored.
- Once released, a domain's reset only reasserts via HOLD entry; there is no partial re-reset.
- Counter arithmetic: unsigned CNT_W bits; never decremented below 0.
- rst asserted mid-sequence: immediate return to reset values; rst_cause returns to 0.

Decomposition:
- Package rst_seq_pkg:
  - state encoding: HOLD, RELEASE, RUN, TRAP_WAIT (2 bits)
  - cause codes: CAUSE_POR=0, CAUSE_BTN=1, CAUSE_SW=2, CAUSE_TRAP=3
- Sub-module rst_debounce: synchronizer, debounce counter and press-edge pulse. Parameterised by DEBOUNCE_CYCLES and CNT_W.

Test Plan:
All tests use HOLD_CYCLES=8, GAP_CYCLES=4, DEBOUNCE_CYCLES=5, N_DOMAINS=3, TRAP_RESET=1.
1. Release rst at edge 0 → sys_rst 111 until edge 8; 110 at edge 8; 100 at edge 12; 000 with rst_done=1 at edge 16; rst_cause=0, busy=0.
2. In RUN, button high with bounce (toggle every 2 cycles for 10 cycles, then steady 10 cycles) → exactly one sequence starts 5 cycles after the steady high is synchronized; rst_cause=1; releases repeat at +8/+12/+16.
3. In RUN, 1-cycle sw_rst_req → next edge sys_rst=111, rst_done=0, rst_cause=2; held high trap_q afterwards does not retrigger.
4. In RUN, trap rises → 4 cycles in TRAP_WAIT with outputs unchanged, then HOLD with rst_cause=3. Repeat with TRAP_RESET=0 → no change.
5. sw_rst_req and trap_rise in the same RUN cycle → rst_cause=2 (software bypasses the trap delay). Button pulse and sw_rst_req together → rst_cause=1.
6. sw_rst_req at edge 10 of the initial sequence (domain 0 released) → sys_rst back to 111 at edge 11; domain 0 next released at edge 19. Then rst low mid-RELEASE → all outputs at reset values asynchronously.
